// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, uart_tx byte port and arbiter status for uart_tx_arbiter.
// master = requesters/uart_tx side, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [IDW-1:0]       grant_id;
    logic                 busy;
    logic                 timeout_evt;

    modport master (
        output req_data, req_valid, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_id, busy, timeout_evt
    );

    modport slave (
        input  req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant_id, busy, timeout_evt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx between NUM_REQ byte streams.
// Optional idle-owner forced release is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_PKT        = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = (MAX_PKT > 0) ? $clog2(MAX_PKT + 1) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] last_ptr;
    logic [IDW-1:0] next_id;
    logic           any_req;
    logic           out_full;
    logic [7:0]     tx_byte;
    logic [BCW-1:0] byte_cnt;
    logic           accept;
    logic           pkt_full;
    logic           timeout_hit;
    logic           release_now;
    int             idx;

    // Scan downward so the requester closest after last_ptr is the final (winning) hit.
    always_comb begin
        any_req = 1'b0;
        next_id = '0;
        idx     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_ptr) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                any_req = 1'b1;
                next_id = IDW'(idx);
            end
        end
    end

    assign accept      = (state == ST_LOCKED) && bus.req_valid[owner] && !out_full;
    assign pkt_full    = (MAX_PKT != 0) && (int'(byte_cnt) + 1 == MAX_PKT);
    assign release_now = (state == ST_LOCKED) &&
                         ((accept && (bus.req_last[owner] || pkt_full)) || timeout_hit);

    assign bus.req_ready = accept ? (NUM_REQ'(1) << owner) : '0;
    assign bus.tx_valid  = out_full;
    assign bus.tx_data   = tx_byte;
    assign bus.grant_id  = owner;
    assign bus.busy      = (state == ST_LOCKED);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int ICW = $clog2(TIMEOUT_CYCLES + 1);

    logic [ICW-1:0] idle_cnt;
    logic           timeout_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive cycle the owner has nothing to offer.
    assign timeout_hit = (state == ST_LOCKED) && !bus.req_valid[owner] &&
                         (int'(idle_cnt) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state != ST_LOCKED || bus.req_valid[owner] || timeout_hit)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign bus.timeout_evt = timeout_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_evt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= '0;
            last_ptr <= IDW'(NUM_REQ - 1);
            out_full <= 1'b0;
            tx_byte  <= '0;
            byte_cnt <= '0;
        end else begin
            // The output register drains independently of ownership changes.
            if (accept) begin
                tx_byte  <= bus.req_data[8*owner +: 8];
                out_full <= 1'b1;
            end else if (out_full && bus.tx_ready) begin
                out_full <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state <= ST_LOCKED;
                        owner <= next_id;
                    end
                end
                default: begin
                    if (release_now) begin
                        state    <= ST_IDLE;
                        last_ptr <= owner;
                        byte_cnt <= '0;
                    end else if (accept && byte_cnt != '1) begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a packet-level round-robin model.
// DUT built with MAX_PKT=4 so forced packet splitting is exercised.
module tb_uart_tx_arbiter;
    localparam int NUM  = 4;
    localparam int IDW  = $clog2(NUM);
    localparam int MAXP = 4;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     d;
        logic           rel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(NUM)) bus();

    uart_tx_arbiter #(
        .NUM_REQ(NUM),
        .MAX_PKT(MAXP),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int model_last = NUM - 1;

    logic [8:0] rq [NUM][$];
    exp_t       exp_q[$];

    task automatic push_pkt(input int id, input int len, input logic [7:0] base, input bit with_last);
        logic [7:0] b;
        for (int j = 0; j < len; j++) begin
            b = base + 8'(j);
            rq[id].push_back({(with_last && j == len - 1), b});
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = NUM - 1;
    endtask

    // Whole-packet round robin: each grant drains bytes until a last flag or MAXP bytes.
    task automatic build_model();
        logic [8:0] mq [NUM][$];
        logic [8:0] b;
        exp_t e;
        int ptr = model_last;
        int w, cnt;
        bit rel;
        exp_q.delete();
        for (int i = 0; i < NUM; i++) mq[i] = rq[i];
        for (int g = 0; g < 1000; g++) begin
            w = -1;
            for (int k = 1; k <= NUM && w < 0; k++)
                if (mq[(ptr + k) % NUM].size() > 0) w = (ptr + k) % NUM;
            if (w < 0) break;
            cnt = 0;
            rel = 1'b0;
            while (!rel && mq[w].size() > 0) begin
                b = mq[w].pop_front();
                cnt++;
                rel = b[8] || (cnt == MAXP);
                e.id = IDW'(w);
                e.d = b[7:0];
                e.rel = rel;
                exp_q.push_back(e);
            end
            ptr = w;
        end
        model_last = ptr;
    endtask

    task automatic run_traffic(input string name, input int budget, input int ready_pct,
                               output int first_acc, output int first_txv);
        logic [7:0] txq[$];
        exp_t e;
        int cyc = 0;
        int acc_id;
        bit prev_acc = 1'b0, prev_rel = 1'b0, more = 1'b1;
        first_acc = -1;
        first_txv = -1;
        build_model();
        while (more && cyc < budget) begin
            @(negedge clk);
            for (int i = 0; i < NUM; i++) begin
                if (rq[i].size() > 0) begin
                    bus.req_valid[i]      = 1'b1;
                    bus.req_data[8*i +: 8] = rq[i][0][7:0];
                    bus.req_last[i]       = rq[i][0][8];
                end else begin
                    bus.req_valid[i]      = 1'b0;
                    bus.req_data[8*i +: 8] = 8'h00;
                    bus.req_last[i]       = 1'b0;
                end
            end
            bus.tx_ready = (int'($urandom_range(0, 99)) < ready_pct);
            #1;
            if (prev_acc) begin
                checks++;
                if (bus.busy !== !prev_rel)
                    $display("FAIL %s busy_after_accept: got %b want %b", name, bus.busy, !prev_rel);
            end
            prev_acc = 1'b0;
            if (bus.tx_valid === 1'b1 && first_txv < 0) first_txv = cyc;
            if (bus.req_ready !== '0) begin
                acc_id = 0;
                for (int i = 0; i < NUM; i++) if (bus.req_ready[i] === 1'b1) acc_id = i;
                if (first_acc < 0) first_acc = cyc;
                checks++;
                if ($countones(bus.req_ready) != 1 || bus.grant_id !== IDW'(acc_id) || rq[acc_id].size() == 0) begin
                    $display("FAIL %s ready_owner: req_ready=%b grant_id=%0d", name, bus.req_ready, bus.grant_id);
                    failures++;
                end else begin
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    else e = '0;
                    checks++;
                    if ({IDW'(acc_id), rq[acc_id][0][7:0]} !== {e.id, e.d}) begin
                        $display("FAIL %s accept_order: got req%0d byte %h want req%0d byte %h",
                                 name, acc_id, rq[acc_id][0][7:0], e.id, e.d);
                        failures++;
                    end
                    txq.push_back(rq[acc_id][0][7:0]);
                    void'(rq[acc_id].pop_front());
                    prev_acc = 1'b1;
                    prev_rel = e.rel;
                end
            end
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                checks++;
                if (txq.size() == 0) begin
                    $display("FAIL %s tx_data: got %h want none", name, bus.tx_data);
                    failures++;
                end else begin
                    if (bus.tx_data !== txq[0]) begin
                        $display("FAIL %s tx_data: got %h want %h", name, bus.tx_data, txq[0]);
                        failures++;
                    end
                    void'(txq.pop_front());
                end
            end
            cyc++;
            more = (txq.size() > 0);
            for (int i = 0; i < NUM; i++) if (rq[i].size() > 0) more = 1'b1;
        end
        checks++;
        if (cyc >= budget || exp_q.size() != 0) begin
            $display("FAIL %s completion: cycles=%0d left_expected=%0d want done within %0d",
                     name, cyc, exp_q.size(), budget);
            failures++;
            for (int i = 0; i < NUM; i++) rq[i].delete();
        end
        @(negedge clk);
        clear_inputs();
        bus.tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.tx_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.tx_valid, bus.tx_data, bus.grant_id, bus.busy, bus.timeout_evt} !== '0) begin
            $display("FAIL reset_outputs: ready=%b txv=%b txd=%h gid=%0d busy=%b tevt=%b want all 0",
                     bus.req_ready, bus.tx_valid, bus.tx_data, bus.grant_id, bus.busy, bus.timeout_evt);
            failures++;
        end
        bus.req_valid = '1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready !== '0 || bus.busy !== 1'b0) begin
            $display("FAIL reset_holds: ready=%b busy=%b want 0 0", bus.req_ready, bus.busy);
            failures++;
        end
        clear_inputs();
        rst = 1'b0;
        model_last = NUM - 1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.grant_id !== '0) begin
            $display("FAIL idle_after_reset: busy=%b gid=%0d want 0 0", bus.busy, bus.grant_id);
            failures++;
        end
    endtask

    task automatic test_single_packet();
        int fa, fv;
        push_pkt(1, 3, 8'h41, 1'b1);
        run_traffic("single_packet", 200, 100, fa, fv);
        checks++;
        if (fa != 1 || fv != 2) begin
            $display("FAIL latency: accept_cycle=%0d txvalid_cycle=%0d want 1 2", fa, fv);
            failures++;
        end
    endtask

    task automatic test_two_requesters();
        int fa, fv;
        do_reset();
        push_pkt(0, 2, 8'hA0, 1'b1);
        push_pkt(2, 2, 8'hB0, 1'b1);
        run_traffic("two_requesters", 300, 60, fa, fv);
    endtask

    task automatic test_round_robin();
        int fa, fv;
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM; i++) push_pkt(i, 1, 8'(16 * i + r), 1'b1);
        run_traffic("round_robin", 400, 80, fa, fv);
    endtask

    task automatic test_max_pkt();
        int fa, fv;
        push_pkt(2, 1, 8'hC0, 1'b1);
        run_traffic("max_pkt_prep", 200, 100, fa, fv);
        push_pkt(3, 6, 8'hD0, 1'b1);
        push_pkt(0, 1, 8'hE0, 1'b1);
        run_traffic("max_pkt", 400, 70, fa, fv);
    endtask

    task automatic test_random();
        int fa, fv;
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < NUM; i++) begin
                int npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++)
                    push_pkt(i, $urandom_range(1, 6), 8'($urandom), 1'b1);
            end
            run_traffic("random", 3000, 50, fa, fv);
        end
    endtask

    task automatic test_reset_midpacket();
        int fa, fv, n = 0;
        bit seen = 1'b0;
        @(negedge clk);
        clear_inputs();
        bus.req_valid[2]     = 1'b1;
        bus.req_data[23:16]  = 8'h77;
        bus.tx_ready         = 1'b0;
        while (n < 10 && !seen) begin
            @(negedge clk);
            #1;
            seen = (bus.tx_valid === 1'b1);
            n++;
        end
        checks++;
        if (!seen || bus.busy !== 1'b1) begin
            $display("FAIL midpacket_setup: tx_valid=%b busy=%b want 1 1", bus.tx_valid, bus.busy);
            failures++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.req_ready, bus.tx_valid, bus.tx_data, bus.grant_id, bus.busy, bus.timeout_evt} !== '0) begin
            $display("FAIL midpacket_reset: ready=%b txv=%b txd=%h gid=%0d busy=%b want all 0",
                     bus.req_ready, bus.tx_valid, bus.tx_data, bus.grant_id, bus.busy);
            failures++;
        end
        @(negedge clk);
        clear_inputs();
        bus.tx_ready = 1'b1;
        rst = 1'b0;
        model_last = NUM - 1;
        for (int i = 0; i < NUM; i++) rq[i].delete();
        push_pkt(3, 2, 8'h30, 1'b1);
        push_pkt(1, 1, 8'h10, 1'b1);
        push_pkt(0, 2, 8'h00, 1'b1);
        run_traffic("after_reset", 300, 100, fa, fv);
    endtask

    task automatic test_timeout();
        int n = 0;
        bit got = 1'b0;
        bit bad = 1'b0;
        @(negedge clk);
        clear_inputs();
        bus.req_valid[1]    = 1'b1;
        bus.req_data[15:8]  = 8'h55;
        bus.tx_ready        = 1'b1;
        while (n < 10 && !got) begin
            @(negedge clk);
            #1;
            got = (bus.req_ready[1] === 1'b1);
            n++;
        end
        checks++;
        if (!got) begin
            $display("FAIL timeout_setup: req_ready=%b want req1 accepted", bus.req_ready);
            failures++;
        end
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 1; c <= 1002; c++) begin
            @(negedge clk);
            clear_inputs();
            #1;
            if (c <= 1000 && (bus.timeout_evt !== 1'b0 || bus.busy !== 1'b1)) bad = 1'b1;
            if (c == 1001) begin
                checks++;
                if (bus.timeout_evt !== 1'b1 || bus.busy !== 1'b0) begin
                    $display("FAIL timeout_release: tevt=%b busy=%b want 1 0", bus.timeout_evt, bus.busy);
                    failures++;
                end
            end
            if (c == 1002) begin
                checks++;
                if (bus.timeout_evt !== 1'b0) begin
                    $display("FAIL timeout_pulse: tevt=%b want 0", bus.timeout_evt);
                    failures++;
                end
            end
        end
        checks++;
        if (bad) begin
            $display("FAIL timeout_early: released before 1000 idle cycles");
            failures++;
        end
`else
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            clear_inputs();
            #1;
            if (bus.timeout_evt !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== IDW'(1)) begin
            $display("FAIL no_timeout_hold: busy=%b gid=%0d want 1 1", bus.busy, bus.grant_id);
            failures++;
        end
        checks++;
        if (bad) begin
            $display("FAIL no_timeout_evt: timeout_evt pulsed, want tied 0");
            failures++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_two_requesters();
        test_round_robin();
        test_max_pkt();
        test_random();
        test_reset_midpacket();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
